// File: rtl/sp_pkg.sv
// Shared command encodings and violation classes for the stack-pointer unit.
package sp_pkg;

   typedef enum logic [2:0] {
      SP_HOLD   = 3'b000,
      SP_CLEAR  = 3'b001,
      SP_PUSH   = 3'b010,
      SP_POP    = 3'b011,
      SP_LOAD   = 3'b100,
      SP_ADJ    = 3'b101,
      SP_CLRERR = 3'b110,
      SP_RSVD   = 3'b111
   } sp_cmd_e;

   // Which end of the stack region a rejected candidate fell past.
   typedef enum logic [1:0] {
      VIOL_NONE = 2'b00,
      VIOL_OVF  = 2'b01,
      VIOL_UNF  = 2'b10
   } sp_viol_e;

endpackage

// File: rtl/sp_unit_if.sv
// Command/status bundle between the control unit and the stack-pointer unit.
interface sp_unit_if #(
   parameter int N = 8
);
   logic [2:0]   ctrl;
   logic [N-1:0] din;
   logic [N-1:0] out;
   logic [N-1:0] level;
   logic         empty;
   logic         full;
   logic         ovf;
   logic         unf;
   logic         fault;

   modport master (output ctrl, din, input out, level, empty, full, ovf, unf, fault);
   modport slave  (input ctrl, din, output out, level, empty, full, ovf, unf, fault);
endinterface

// File: rtl/sp_bounds_check.sv
// Computes the candidate next pointer for a command and classifies it against the
// stack region, using N+2-bit signed arithmetic so no candidate can wrap.
module sp_bounds_check
   import sp_pkg::*;
#(
   parameter int           N     = 8,
   parameter bit           DOWN  = 1'b1,
   parameter logic [N-1:0] BASE  = 8'hFF,
   parameter logic [N-1:0] LIMIT = 8'hF0
) (
   input  logic [N-1:0] ptr,
   input  sp_cmd_e      cmd,
   input  logic [N-1:0] din,
   output logic [N-1:0] cand,
   output logic         in_range,
   output sp_viol_e     viol
);

   typedef logic signed [N+1:0] wide_t;

   localparam logic [N-1:0] SPAN   = DOWN ? BASE - LIMIT : LIMIT - BASE;
   localparam wide_t        SPAN_W = signed'({2'b00, SPAN});
   localparam wide_t        BASE_W = signed'({2'b00, BASE});
   localparam wide_t        ONE_W  = wide_t'(1);

   wide_t ptr_w;
   wide_t din_w;
   wide_t cand_w;
   wide_t dist_w;

   // NOTE: every output of a combinational block gets a default before any branch;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      ptr_w  = signed'({2'b00, ptr});
      din_w  = signed'({{2{din[N-1]}}, din});
      cand_w = ptr_w;
      case (cmd)
         SP_CLEAR: cand_w = BASE_W;
         SP_PUSH:  cand_w = DOWN ? ptr_w - ONE_W : ptr_w + ONE_W;
         SP_POP:   cand_w = DOWN ? ptr_w + ONE_W : ptr_w - ONE_W;
         SP_LOAD:  cand_w = signed'({2'b00, din});
         SP_ADJ:   cand_w = DOWN ? ptr_w - din_w : ptr_w + din_w;
         default:  cand_w = ptr_w;
      endcase

      // Distance travelled from BASE toward LIMIT: negative is past BASE,
      // beyond SPAN is past LIMIT.
      dist_w = DOWN ? BASE_W - cand_w : cand_w - BASE_W;
      viol   = VIOL_NONE;
      if (dist_w[N+1]) begin
         viol = VIOL_UNF;
      end else if (dist_w > SPAN_W) begin
         viol = VIOL_OVF;
      end
      in_range = (viol == VIOL_NONE);
      cand     = cand_w[N-1:0];
   end

endmodule

// File: rtl/sp_unit.sv
// Stack-pointer unit: registered pointer with sticky overflow/underflow flags and a
// one-cycle fault pulse for every rejected command.
module sp_unit
   import sp_pkg::*;
#(
   parameter int           N     = 8,
   parameter bit           DOWN  = 1'b1,
   parameter logic [N-1:0] BASE  = 8'hFF,
   parameter logic [N-1:0] LIMIT = 8'hF0
) (
   input  logic       clk,
   input  logic       rst,
   sp_unit_if.slave   bus
);

   generate
      if (BASE == LIMIT || (DOWN && LIMIT > BASE) || (!DOWN && LIMIT < BASE)) begin : g_bad_cfg
         $error("sp_unit: BASE/LIMIT must differ and agree with the growth direction DOWN");
      end
   endgenerate

   sp_cmd_e      cmd;
   logic [N-1:0] cand;
   logic         in_range;
   sp_viol_e     viol;

   logic [N-1:0] out_q, out_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;
   logic         fault_q, fault_d;

   assign cmd = sp_cmd_e'(bus.ctrl);

   sp_bounds_check #(
      .N     (N),
      .DOWN  (DOWN),
      .BASE  (BASE),
      .LIMIT (LIMIT)
   ) u_bounds (
      .ptr      (out_q),
      .cmd      (cmd),
      .din      (bus.din),
      .cand     (cand),
      .in_range (in_range),
      .viol     (viol)
   );

   always_comb begin
      out_d   = in_range ? cand : out_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      fault_d = 1'b0;
      // Only moving commands can violate, so flag clearing never races flag setting.
      if (cmd == SP_CLEAR || cmd == SP_CLRERR) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else if (viol == VIOL_OVF) begin
         ovf_d   = 1'b1;
         fault_d = 1'b1;
      end else if (viol == VIOL_UNF) begin
         unf_d   = 1'b1;
         fault_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= BASE;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         fault_q <= fault_d;
      end
   end

   assign bus.out   = out_q;
   assign bus.level = DOWN ? BASE - out_q : out_q - BASE;
   assign bus.empty = (out_q == BASE);
   assign bus.full  = (out_q == LIMIT);
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_sp_unit.sv
// Scoreboard bench for sp_unit (N=8, DOWN=1, BASE=FF, LIMIT=F0): an occupancy-count
// model predicts each cycle's outputs, and a monitor compares them after each edge.
`timescale 1ns/1ps
module tb_sp_unit;
   import sp_pkg::*;

   localparam int BASE = 255;
   localparam int SPAN = 15;

   typedef struct {
      logic [7:0] out;
      int         lvl;
      bit         ovf;
      bit         unf;
      bit         fault;
   } exp_t;

   logic clk;
   logic rst;
   sp_unit_if #(.N(8)) bus ();

   sp_unit #(
      .N     (8),
      .DOWN  (1'b1),
      .BASE  (8'hFF),
      .LIMIT (8'hF0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state: occupancy count plus the two sticky flags.
   int   m_lvl = 0;
   bit   m_ovf = 1'b0;
   bit   m_unf = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lvl = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Drive one command for the next edge and queue the predicted result.
   task automatic issue(input sp_cmd_e c, input logic [7:0] d);
      exp_t e;
      int   tgt;
      bit   move;
      @(negedge clk);
      bus.ctrl = c;
      bus.din  = d;
      e.fault  = 1'b0;
      move     = 1'b0;
      tgt      = m_lvl;
      case (c)
         SP_CLEAR:  begin m_lvl = 0; m_ovf = 1'b0; m_unf = 1'b0; end
         SP_CLRERR: begin m_ovf = 1'b0; m_unf = 1'b0; end
         SP_PUSH:   begin tgt = m_lvl + 1; move = 1'b1; end
         SP_POP:    begin tgt = m_lvl - 1; move = 1'b1; end
         SP_LOAD:   begin tgt = BASE - int'(d); move = 1'b1; end
         SP_ADJ:    begin tgt = m_lvl + int'($signed(d)); move = 1'b1; end
         default:   ;
      endcase
      if (move) begin
         if (tgt > SPAN) begin
            m_ovf   = 1'b1;
            e.fault = 1'b1;
         end else if (tgt < 0) begin
            m_unf   = 1'b1;
            e.fault = 1'b1;
         end else begin
            m_lvl = tgt;
         end
      end
      e.out = 8'(BASE - m_lvl);
      e.lvl = m_lvl;
      e.ovf = m_ovf;
      e.unf = m_unf;
      sb_q.push_back(e);
   endtask

   // Returns after the edge that executed the last issued command and its monitor check.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out",   32'(bus.out),   32'(e.out));
            check("level", 32'(bus.level), 32'(e.lvl));
            check("empty", 32'(bus.empty), 32'(e.lvl == 0));
            check("full",  32'(bus.full),  32'(e.lvl == SPAN));
            check("ovf",   32'(bus.ovf),   32'(e.ovf));
            check("unf",   32'(bus.unf),   32'(e.unf));
            check("fault", 32'(bus.fault), 32'(e.fault));
         end
      end
   end

   initial begin : stimulus
      sp_cmd_e c;
      logic [7:0] d;
      int v;

      rst      = 1'b1;
      bus.ctrl = SP_HOLD;
      bus.din  = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      check("rst_out",   32'(bus.out),   32'h0FF);
      check("rst_level", 32'(bus.level), 32'h0);
      check("rst_empty", 32'(bus.empty), 32'h1);
      check("rst_full",  32'(bus.full),  32'h0);
      check("rst_ovf",   32'(bus.ovf),   32'h0);
      check("rst_unf",   32'(bus.unf),   32'h0);
      check("rst_fault", 32'(bus.fault), 32'h0);
      rst = 1'b0;
      model_reset();

      // Fill to LIMIT, then one push too many.
      repeat (15) issue(SP_PUSH, 8'h00);
      settle();
      check("fill_out",   32'(bus.out),   32'h0F0);
      check("fill_full",  32'(bus.full),  32'h1);
      check("fill_level", 32'(bus.level), 32'd15);
      issue(SP_PUSH, 8'h00);
      settle();
      check("ovf_out",   32'(bus.out),   32'h0F0);
      check("ovf_set",   32'(bus.ovf),   32'h1);
      check("ovf_fault", 32'(bus.fault), 32'h1);
      issue(SP_POP, 8'h00);
      settle();
      check("pop_full_clears", 32'(bus.full),  32'h0);
      check("fault_one_cycle", 32'(bus.fault), 32'h0);

      // Underflow on an empty stack, then error clear.
      issue(SP_CLEAR, 8'h00);
      issue(SP_POP, 8'h00);
      settle();
      check("unf_out", 32'(bus.out), 32'h0FF);
      check("unf_set", 32'(bus.unf), 32'h1);
      issue(SP_CLRERR, 8'h00);
      settle();
      check("clrerr_unf", 32'(bus.unf), 32'h0);

      // Signed adjust sequence.
      issue(SP_ADJ, 8'h05);
      settle();
      check("adj5_out",   32'(bus.out),   32'h0FA);
      check("adj5_level", 32'(bus.level), 32'd5);
      issue(SP_ADJ, 8'hFB);
      settle();
      check("adjm5_empty", 32'(bus.empty), 32'h1);
      issue(SP_ADJ, 8'h20);
      settle();
      check("adj20_ovf", 32'(bus.ovf), 32'h1);
      check("adj20_out", 32'(bus.out), 32'h0FF);

      // Absolute load inside and outside the region.
      issue(SP_CLRERR, 8'h00);
      issue(SP_LOAD, 8'hF8);
      settle();
      check("load_f8", 32'(bus.out), 32'h0F8);
      issue(SP_LOAD, 8'hE0);
      settle();
      check("load_e0_out", 32'(bus.out), 32'h0F8);
      check("load_e0_ovf", 32'(bus.ovf), 32'h1);
      issue(SP_ADJ, 8'h00);
      issue(SP_RSVD, 8'h55);

      // Back-to-back push/pop from empty.
      issue(SP_CLEAR, 8'h00);
      for (int i = 0; i < 10; i++) issue((i % 2 == 0) ? SP_PUSH : SP_POP, 8'h00);

      // Randomised commands with operands biased toward the region edges.
      for (int i = 0; i < 400; i++) begin
         c = sp_cmd_e'(3'($urandom_range(0, 7)));
         case ($urandom_range(0, 3))
            0:       d = 8'($urandom);
            1:       d = 8'($urandom_range(8'hE8, 8'hFF));
            default: begin
               v = int'($urandom_range(0, 40)) - 20;
               d = 8'(v);
            end
         endcase
         issue(c, d);
      end

      // Asynchronous reset between edges with a non-empty pointer and ovf set.
      issue(SP_CLEAR, 8'h00);
      issue(SP_LOAD, 8'hF3);
      issue(SP_LOAD, 8'hE0);
      settle();
      check("pre_rst_out", 32'(bus.out), 32'h0F3);
      check("pre_rst_ovf", 32'(bus.ovf), 32'h1);
      #1;
      bus.ctrl = SP_HOLD;
      rst = 1'b1;
      #1;
      check("async_rst_out", 32'(bus.out), 32'h0FF);
      check("async_rst_ovf", 32'(bus.ovf), 32'h0);
      rst = 1'b0;
      model_reset();
      issue(SP_PUSH, 8'h00);
      settle();
      check("post_rst_push", 32'(bus.out), 32'h0FE);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sp_unit.md
# sp_unit

Parametrised stack-pointer unit with configurable width, growth direction and stack bounds. Executes hold/clear/push/pop/load/adjust commands on a single registered pointer, and refuses any move that would leave the stack region. Reports occupancy, empty/full status and sticky overflow/underflow errors. Sits in the processor datapath beside the register file and drives the stack address into the memory address mux.

## Interface
- `N`, default 8: pointer width in bits.
- `DOWN`, default 1: growth direction. 1 = push decrements, 0 = push increments.
- `BASE`, default 8'hFF: pointer value when the stack is empty. Also the reset value.
- `LIMIT`, default 8'hF0: pointer value when the stack is full. Elaboration error if `BASE == LIMIT`, or if the direction disagrees with `DOWN` (`DOWN=1` requires `LIMIT < BASE`).
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `ctrl`, input, 3: command code; encodings are listed under Operation.
- `din`, input, N: operand for LOAD (absolute value) and ADJ (signed N-bit offset).
- `out`, output, N: current stack pointer (registered).
- `level`, output, N: number of occupied entries, |BASE − out|.
- `empty`, output, 1: high when `out == BASE`.
- `full`, output, 1: high when `out == LIMIT`.
- `ovf`, output, 1: sticky overflow (attempted move beyond LIMIT).
- `unf`, output, 1: sticky underflow (attempted move beyond BASE).
- `fault`, output, 1: one-cycle pulse on any rejected command.

## Operation
- 000 HOLD: no change.
- 001 CLEAR: `out` ← BASE; clears `ovf` and `unf`.
- 010 PUSH: move `out` one step toward LIMIT. If `full`: `out` unchanged, set `ovf`.
- 011 POP: move `out` one step toward BASE. If `empty`: `out` unchanged, set `unf`.
- 100 LOAD: `out` ← `din` if `din` lies in the inclusive range between BASE and LIMIT.
  - Outside on the LIMIT side: reject and set `ovf`.
  - Outside on the BASE side: reject and set `unf`.
- 101 ADJ: `din` is signed. A positive value allocates (moves toward LIMIT); a negative value releases (moves toward BASE).
  - Compute the candidate in N+2-bit signed arithmetic; no wrap-around is permitted.
  - Range check and rejection follow the same rules as LOAD.
  - `din = 0` behaves as HOLD.
- 110 CLRERR: clears `ovf` and `unf`; `out` unchanged.
- 111: reserved; behaves as HOLD.
- A rejected command never modifies `out`.
- `fault` is high for exactly one cycle per rejected command. A flag that is already set stays set.
- Within one cycle, CLEAR and CLRERR take priority over flag setting; a flag set and cleared by the same command cannot occur.

## Timing
- Reset: `out`=BASE, `ovf`=0, `unf`=0, `fault`=0, so `empty`=1, `full`=0, `level`=0. Takes effect immediately, independent of `clk`, including mid-sequence.
- Command latency: one cycle. `ctrl`/`din` are sampled at edge k; `out`, flags and `fault` are valid after edge k.
- `level`, `empty` and `full` are combinational from registered `out`, with no extra latency.
- Back-to-back commands are accepted every cycle; there is no handshake or busy state.
- Boundary cases:
  - Push at LIMIT−1 step → `full` next cycle.
  - Pop from `full` clears `full`.
  - BASE or LIMIT at 0 or 2^N−1 must not wrap.

## Structure
- Package `sp_pkg` holds the 3-bit ctrl encoding constants (SP_HOLD, SP_CLEAR, SP_PUSH, SP_POP, SP_LOAD, SP_ADJ, SP_CLRERR) for shared use by the control unit and the bench.
- One combinational sub-module, `sp_bounds_check`:
  - Inputs: the current pointer, command and operand.
  - Outputs: the candidate next pointer, an in-range flag and the violation side.
  - The top level holds only the registers and the flag/fault logic.

## Test plan
All scenarios use N=8, DOWN=1, BASE=8'hFF, LIMIT=8'hF0.
- Reset, then 15 PUSH → `out` = 8'hF0, `full`=1, `level`=15. A 16th PUSH → `out` stays 8'hF0, `ovf`=1, `fault` high one cycle.
- After CLEAR, POP → `out` stays 8'hFF, `unf`=1, `fault` pulse. CLRERR → `unf`=0, `out`=8'hFF.
- ADJ sequence from 8'hFF:
  - ADJ `din`=8'h05 → 8'hFA, `level`=5.
  - ADJ `din`=8'hFB (−5) → 8'hFF, `empty`=1.
  - ADJ `din`=8'h20 → rejected, `ovf`=1, `out` 8'hFF.
- LOAD `din`=8'hF8 → `out`=8'hF8. LOAD `din`=8'hE0 → rejected, `ovf`=1, `out` 8'hF8.
- Alternate PUSH/POP every cycle for 10 cycles from 8'hFF → `out` toggles FE/FF, no `fault`.
- Assert `rst` between clock edges with `out`=8'hF3 and `ovf`=1 → `out`=8'hFF, `ovf`=0 before the next edge. Deassert, then PUSH → 8'hFE.
